// File: rtl/step_pulse_gen_pkg.sv
// Shared encodings and helpers for the step pulse generator: mode and hybrid
// segment enums, the segment schedule and the rate-to-period conversion.
package step_pulse_gen_pkg;

  typedef enum logic [1:0] {
    MODE_WALK = 2'b00,
    MODE_JOG  = 2'b01,
    MODE_RUN  = 2'b10,
    MODE_HYB  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    SEG_WALK = 2'b00,
    SEG_JOG  = 2'b01,
    SEG_RUN  = 2'b10,
    SEG_JOG2 = 2'b11
  } seg_t;

  function automatic int rate_to_period(input int clk_hz, input int rate_hz);
    return clk_hz / rate_hz;
  endfunction

  // Hybrid schedule: walk -> jog -> run -> jog -> walk ...
  function automatic seg_t seg_after(input seg_t seg);
    case (seg)
      SEG_WALK: return SEG_JOG;
      SEG_JOG:  return SEG_RUN;
      SEG_RUN:  return SEG_JOG2;
      default:  return SEG_WALK;
    endcase
  endfunction

  // Fixed-rate speed actually in effect for a mode (and segment, in hybrid).
  function automatic mode_t speed_of(input mode_t mode, input seg_t seg);
    if (mode != MODE_HYB) return mode;
    case (seg)
      SEG_WALK: return MODE_WALK;
      SEG_RUN:  return MODE_RUN;
      default:  return MODE_JOG;
    endcase
  endfunction

endpackage

// File: rtl/step_pulse_gen_period_timer.sv
// Free-running modulo counter: counts 0..last while enabled and strobes wrap
// in the cycle it sits at last, so one wrap occurs every last+1 cycles.
module step_pulse_gen_period_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] last,
  input  logic         restart,
  input  logic         enable,
  output logic         wrap
);

  logic [W-1:0] count;

  assign wrap = enable && (count == last);

  // NOTE: state registers use non-blocking assignments, and the synchronous
  // reset is just the highest-priority branch inside the clocked block.
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/step_pulse_gen.sv
// Step pulse generator: walk/jog/run fixed rates plus a hybrid schedule,
// with arm/disarm control, saturating pulse counter and current-rate status.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int RATE_WALK = 32,
  parameter int RATE_JOG  = 64,
  parameter int RATE_RUN  = 128,
  parameter int SEG_SEC   = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk100Mhz,
  input  logic             rst,
  input  logic [1:0]       MODE,
  input  logic             START,
  input  logic             STOP,
  input  logic             CLEAR,
  output logic             pulse,
  output logic             running,
  output logic [CNT_W-1:0] pulse_count,
  output logic [7:0]       rate
);

  // The segment timer has the largest terminal count; both timers share its width.
  localparam int TW = $clog2(SEG_SEC * CLK_HZ);

  function automatic logic [7:0] rate_of(input mode_t speed);
    case (speed)
      MODE_WALK: return 8'(RATE_WALK);
      MODE_JOG:  return 8'(RATE_JOG);
      default:   return 8'(RATE_RUN);
    endcase
  endfunction

  function automatic logic [TW-1:0] last_of(input mode_t speed);
    case (speed)
      MODE_WALK: return TW'(rate_to_period(CLK_HZ, RATE_WALK) - 1);
      MODE_JOG:  return TW'(rate_to_period(CLK_HZ, RATE_JOG) - 1);
      default:   return TW'(rate_to_period(CLK_HZ, RATE_RUN) - 1);
    endcase
  endfunction

  mode_t            mode_in, mode_q;
  seg_t             seg_q, seg_d;
  logic             running_d, mode_chg, seg_adv, pulse_d;
  logic             p_wrap, s_wrap, p_restart, s_restart, s_enable;
  logic [TW-1:0]    p_last;
  logic [CNT_W-1:0] count_d;
  logic [7:0]       rate_d;

  assign mode_in = mode_t'(MODE);

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    running_d = running;
    if (STOP)       running_d = 1'b0;
    else if (START) running_d = 1'b1;

    mode_chg = running && (mode_in != mode_q);
    seg_adv  = s_wrap && !mode_chg && !STOP;

    seg_d = seg_q;
    if (!running_d || mode_chg) seg_d = SEG_WALK;
    else if (seg_adv)           seg_d = seg_after(seg_q);

    // A period that completes exactly on a segment boundary still pulses;
    // only a mode change or a stop swallows it.
    pulse_d = p_wrap && !mode_chg && !STOP;

    count_d = pulse_count;
    if (CLEAR)                               count_d = '0;
    else if (pulse_d && (pulse_count != '1)) count_d = pulse_count + CNT_W'(1);

    rate_d    = running_d ? rate_of(speed_of(mode_in, seg_d)) : 8'd0;
    p_last    = last_of(speed_of(mode_q, seg_q));
    p_restart = !running_d || mode_chg || seg_adv;
    s_restart = !running_d || mode_chg;
    s_enable  = running && (mode_q == MODE_HYB);
  end

  step_pulse_gen_period_timer #(.W(TW)) u_step_timer (
    .clk     (clk100Mhz),
    .rst_n   (rst),
    .last    (p_last),
    .restart (p_restart),
    .enable  (running),
    .wrap    (p_wrap)
  );

  step_pulse_gen_period_timer #(.W(TW)) u_seg_timer (
    .clk     (clk100Mhz),
    .rst_n   (rst),
    .last    (TW'(SEG_SEC * CLK_HZ - 1)),
    .restart (s_restart),
    .enable  (s_enable),
    .wrap    (s_wrap)
  );

  always_ff @(posedge clk100Mhz) begin
    if (!rst) begin
      running     <= 1'b0;
      mode_q      <= MODE_WALK;
      seg_q       <= SEG_WALK;
      pulse       <= 1'b0;
      pulse_count <= '0;
      rate        <= 8'd0;
    end else begin
      running     <= running_d;
      mode_q      <= mode_in;
      seg_q       <= seg_d;
      pulse       <= pulse_d;
      pulse_count <= count_d;
      rate        <= rate_d;
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench: expected pulse cycles are queued as stimulus is applied and
// popped by a monitor as the generator emits pulses.
module tb_step_pulse_gen;

  logic        clk = 1'b0;
  logic        rst, start, stop, clear;
  logic [1:0]  mode;
  logic        pulse, running;
  logic [15:0] pulse_count;
  logic [7:0]  rate;

  logic        s_start, s_stop, s_clear;
  logic [1:0]  s_mode;
  logic        s_pulse, s_running;
  logic [3:0]  s_count;
  logic [7:0]  s_rate;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  step_pulse_gen #(.CLK_HZ(1280), .SEG_SEC(1), .CNT_W(16)) dut (
    .clk100Mhz   (clk),
    .rst         (rst),
    .MODE        (mode),
    .START       (start),
    .STOP        (stop),
    .CLEAR       (clear),
    .pulse       (pulse),
    .running     (running),
    .pulse_count (pulse_count),
    .rate        (rate)
  );

  step_pulse_gen #(.CLK_HZ(1280), .SEG_SEC(1), .CNT_W(4)) dut_small (
    .clk100Mhz   (clk),
    .rst         (rst),
    .MODE        (s_mode),
    .START       (s_start),
    .STOP        (s_stop),
    .CLEAR       (s_clear),
    .pulse       (s_pulse),
    .running     (s_running),
    .pulse_count (s_count),
    .rate        (s_rate)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick(1);
  endtask

  // Every pulse must match the oldest queued cycle; a pulse with nothing queued fails.
  always @(negedge clk) begin : monitor
    int want;
    if (pulse === 1'b1) begin
      want = -1;
      if (exp_q.size() != 0) want = exp_q.pop_front();
      check("pulse_cycle", cyc, want);
    end
  end

  initial begin
    int t, h, c0, c1, cum;
    int per[5];
    int num[5];
    int rt[5];
    per = '{40, 20, 10, 20, 40};
    num = '{32, 64, 128, 64, 32};
    rt  = '{32, 64, 128, 64, 32};

    rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; mode = 2'b00;
    s_start = 1'b0; s_stop = 1'b0; s_clear = 1'b0; s_mode = 2'b10;
    tick(3);
    check("rst_pulse", pulse, 0);
    check("rst_running", running, 0);
    check("rst_count", pulse_count, 0);
    check("rst_rate", rate, 0);
    check("rst_small_count", s_count, 0);
    rst = 1'b1;
    tick(2);
    check("idle_running", running, 0);

    // Walk: first pulse START+40, then every 40; 32 pulses in one second.
    t = cyc + 1;
    start = 1'b1;
    for (int k = 1; k <= 32; k++) exp_q.push_back(t + 40 * k);
    tick(1);
    start = 1'b0;
    check("walk_running", running, 1);
    check("walk_rate", rate, 32);
    tick(1279);
    check("walk_one_left", exp_q.size(), 1);
    tick(1);
    check("walk_drained", exp_q.size(), 0);
    check("walk_count", pulse_count, 32);

    // Jog, then switch to run mid-period: re-timed from the change.
    mode = 2'b01;
    c0 = cyc + 1;
    for (int k = 1; k <= 3; k++) exp_q.push_back(c0 + 20 * k);
    tick(1);
    check("jog_rate", rate, 64);
    tick_to(c0 + 65);
    check("jog_drained", exp_q.size(), 0);
    mode = 2'b10;
    c1 = cyc + 1;
    for (int k = 1; k <= 5; k++) exp_q.push_back(c1 + 10 * k);
    tick(1);
    check("run_rate", rate, 128);
    tick_to(c1 + 50);
    check("run_drained", exp_q.size(), 0);
    check("run_count", pulse_count, 40);

    // Hybrid for five seconds, counter cleared on entry.
    mode = 2'b11;
    clear = 1'b1;
    h = cyc + 1;
    for (int s = 0; s < 5; s++)
      for (int k = 1; k <= num[s]; k++) exp_q.push_back(h + 1280 * s + per[s] * k);
    tick(1);
    clear = 1'b0;
    check("hyb_cleared", pulse_count, 0);
    cum = 0;
    for (int s = 0; s < 5; s++) begin
      tick_to(h + 1280 * s + 640);
      check("hyb_rate", rate, rt[s]);
      tick_to(h + 1280 * (s + 1));
      cum += num[s];
      check("hyb_count", pulse_count, cum);
    end
    check("hyb_drained", exp_q.size(), 0);
    check("hyb_total", pulse_count, 320);

    // STOP wins over START; stopped generator stays silent and frozen.
    stop = 1'b1;
    tick(1);
    check("stop_running", running, 0);
    check("stop_rate", rate, 0);
    start = 1'b1;
    tick(1);
    check("both_running", running, 0);
    tick(80);
    check("both_still_idle", running, 0);
    check("both_count", pulse_count, 320);

    stop = 1'b0;
    mode = 2'b01;
    t = cyc + 1;
    exp_q.push_back(t + 20);
    exp_q.push_back(t + 40);
    tick(1);
    start = 1'b0;
    tick_to(t + 45);
    stop = 1'b1;
    tick(1);
    check("stop2_running", running, 0);
    stop = 1'b0;
    tick(100);
    check("stop2_drained", exp_q.size(), 0);
    check("stop2_frozen", pulse_count, 322);

    t = cyc + 1;
    start = 1'b1;
    exp_q.push_back(t + 20);
    tick(1);
    start = 1'b0;
    tick_to(t + 25);
    check("restart_drained", exp_q.size(), 0);
    check("restart_count", pulse_count, 323);

    // Into hybrid, then reset mid-jog-segment and mid-period.
    mode = 2'b11;
    h = cyc + 1;
    for (int k = 1; k <= 32; k++) exp_q.push_back(h + 40 * k);
    exp_q.push_back(h + 1300);
    tick_to(h + 1310);
    check("hyb2_drained", exp_q.size(), 0);
    check("hyb2_count", pulse_count, 356);
    check("hyb2_rate", rate, 64);
    rst = 1'b0;
    tick(1);
    check("mid_rst_pulse", pulse, 0);
    check("mid_rst_running", running, 0);
    check("mid_rst_count", pulse_count, 0);
    check("mid_rst_rate", rate, 0);
    rst = 1'b1;
    tick(100);
    check("post_rst_running", running, 0);
    check("post_rst_count", pulse_count, 0);

    // Narrow counter saturates at 15; CLEAR beats a same-cycle pulse.
    t = cyc + 1;
    s_start = 1'b1;
    tick(1);
    s_start = 1'b0;
    check("small_rate", s_rate, 128);
    tick_to(t + 155);
    check("small_at_15", s_count, 15);
    tick_to(t + 205);
    check("small_saturated", s_count, 15);
    check("small_running", s_running, 1);
    tick_to(t + 209);
    s_clear = 1'b1;
    tick(1);
    check("small_clear_pulse", s_pulse, 1);
    check("small_clear_count", s_count, 0);
    s_clear = 1'b0;
    tick_to(t + 220);
    check("small_after_clear", s_count, 1);
    s_stop = 1'b1;
    tick(2);
    check("small_stopped", s_running, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
